// File: rtl/dds_key_ctrl.sv
// Front-panel controller for the DDS/PWM path: debounces eight keys, queues one-shot
// commands and commits frequency word, phase offset and modulation depth to the
// datapath through a ready/load handshake.
module dds_key_ctrl #(
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned AMP_W      = 12,
  parameter int unsigned DEB_CYCLES = 200,
  parameter int unsigned FREQ_INIT  = 1678,
  parameter int unsigned FREQ_STEP  = 1678,
  parameter int unsigned FREQ_MIN   = 1678,
  parameter int unsigned FREQ_MAX   = 2**(PHASE_W-1)-1,
  parameter int unsigned AMP_INIT   = 1024,
  parameter int unsigned AMP_STEP   = 204,
  parameter int unsigned AMP_MAX    = 1844
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key0,
  input  logic                      key1,
  input  logic                      key2,
  input  logic                      key3,
  input  logic                      key4,
  input  logic                      key5,
  input  logic                      key6,
  input  logic                      key7,
  input  logic                      cfg_ready,
  output logic [PHASE_W-1:0]        freq_word,
  output logic [PHASE_W-1:0]        phase_shift,
  output logic signed [AMP_W-1:0]   m,
  output logic                      cfg_load,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // One extra bit of headroom so sums/differences can be clamped without wrapping.
  typedef logic signed [PHASE_W:0] fext_t;
  typedef logic signed [AMP_W:0]   mext_t;

  localparam fext_t F_MIN  = fext_t'(FREQ_MIN);
  localparam fext_t F_MAX  = fext_t'(FREQ_MAX);
  localparam fext_t F_STEP = fext_t'(FREQ_STEP);
  localparam mext_t M_MAX  = mext_t'(AMP_MAX);
  localparam mext_t M_NEG  = mext_t'(-int'(AMP_MAX));
  localparam mext_t M_STEP = mext_t'(AMP_STEP);

  localparam logic [PHASE_W-1:0] F_INIT    = PHASE_W'(FREQ_INIT);
  localparam logic [AMP_W-1:0]   M_INIT    = AMP_W'(AMP_INIT);
  localparam logic [PHASE_W-1:0] PHASE_QTR = PHASE_W'(1) << (PHASE_W - 2);

  typedef enum logic [1:0] {StIdle, StApply, StLoad} state_e;

  logic [7:0]       keys;
  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       stable_q, stable_prev_q;
  logic [CNT_W-1:0] cnt_q [8];
  logic [7:0]       rise;

  state_e             state_q;
  logic [7:0]         pend_q;
  logic [2:0]         cmd_q;
  logic [PHASE_W-1:0] freq_q, phase_q;
  logic [AMP_W-1:0]   m_q;
  logic [PHASE_W-1:0] sh_freq_q, sh_phase_q;
  logic [AMP_W-1:0]   sh_m_q;
  logic               cfg_load_q;

  logic [2:0]         sel_idx;
  logic [7:0]         clr;
  fext_t              f_res;
  mext_t              m_res;
  logic [PHASE_W-1:0] p_res;

  assign keys = {key7, key6, key5, key4, key3, key2, key1, key0};

  // Synchronise raw keys and debounce each one with its own stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= keys;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 8; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            stable_q[i] <= sync2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Only presses produce commands; releases are ignored.
  assign rise = stable_q & ~stable_prev_q;

  // Pick the lowest pending index; key0 has highest priority.
  always_comb begin
    sel_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = 3'(i);
    end
    clr = '0;
    if (state_q == StIdle && pend_q != '0) clr = 8'b1 << sel_idx;
  end

  // Apply the latched command to the current outputs and clamp the results.
  always_comb begin
    f_res = fext_t'({1'b0, freq_q});
    m_res = mext_t'({m_q[AMP_W-1], m_q});
    p_res = phase_q;
    unique case (cmd_q)
      3'd0: begin
        f_res = fext_t'({1'b0, F_INIT});
        m_res = mext_t'({M_INIT[AMP_W-1], M_INIT});
        p_res = '0;
      end
      3'd1: f_res = f_res + F_STEP;
      3'd2: f_res = f_res - F_STEP;
      3'd3: f_res = f_res <<< 1;
      3'd4: f_res = f_res >>> 1;
      3'd5: m_res = m_res + M_STEP;
      3'd6: m_res = m_res - M_STEP;
      3'd7: p_res = phase_q + PHASE_QTR;
    endcase
    if (f_res > F_MAX) begin
      f_res = F_MAX;
    end else if (f_res < F_MIN) begin
      f_res = F_MIN;
    end
    if (m_res > M_MAX) begin
      m_res = M_MAX;
    end else if (m_res < M_NEG) begin
      m_res = M_NEG;
    end
  end

  // Command FSM: pick a pending key, build shadow config, commit on cfg_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      cmd_q      <= '0;
      freq_q     <= F_INIT;
      phase_q    <= '0;
      m_q        <= M_INIT;
      sh_freq_q  <= F_INIT;
      sh_phase_q <= '0;
      sh_m_q     <= M_INIT;
      cfg_load_q <= 1'b0;
    end else begin
      cfg_load_q <= 1'b0;
      // A new press wins over a same-cycle clear of the same bit.
      pend_q     <= (pend_q & ~clr) | rise;
      case (state_q)
        StIdle: begin
          if (pend_q != '0) begin
            cmd_q   <= sel_idx;
            state_q <= StApply;
          end
        end
        StApply: begin
          sh_freq_q  <= f_res[PHASE_W-1:0];
          sh_phase_q <= p_res;
          sh_m_q     <= m_res[AMP_W-1:0];
          state_q    <= StLoad;
        end
        StLoad: begin
          if (cfg_ready) begin
            freq_q     <= sh_freq_q;
            phase_q    <= sh_phase_q;
            m_q        <= sh_m_q;
            cfg_load_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign freq_word   = freq_q;
  assign phase_shift = phase_q;
  assign m           = m_q;
  assign cfg_load    = cfg_load_q;
  assign busy        = (state_q != StIdle) | (pend_q != '0);

endmodule
